// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline feeding execute: forwarding selects,
// load-use stalls, branch flushes, filter-coprocessor hold with timeout, and perf counters.
module pipeline_ctrl #(
    parameter int unsigned ACC_TIMEOUT = 1024,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_w_idx,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic [4:0]        mem_w_idx,
    input  logic              mem_wb_en,
    input  logic              ex_do_branch,
    input  logic              ex_acc_start,
    input  logic              acc_done,
    output logic [1:0]        r1_fw_sel,
    output logic [1:0]        r2_fw_sel,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic              acc_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int unsigned TimerW = $clog2(ACC_TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ACC_TIMEOUT - 1);

    typedef enum logic [0:0] {StRun, StAccWait} state_e;

    state_e              state_q;
    logic [TimerW-1:0]   timer_q;
    logic [1:0]          r1_fw_q, r2_fw_q;
    logic                acc_err_q;
    logic [PERF_W-1:0]   stall_cnt_q, flush_cnt_q;

    logic                load_use;
    logic                acc_exit;

    // EX match beats MEM match; x0 never forwards.
    function automatic logic [1:0] fw_sel(input logic [4:0] rs, input logic use_rs,
                                          input logic [4:0] ex_idx, input logic ex_wb,
                                          input logic [4:0] mem_idx, input logic mem_wb);
        if (rs == 5'd0 || !use_rs) return 2'd0;
        if (rs == ex_idx && ex_wb) return 2'd1;
        if (rs == mem_idx && mem_wb) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        load_use  = ex_is_load && ex_wb_en && (ex_w_idx != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_w_idx) || (id_use_rs2 && id_rs2 == ex_w_idx));
        acc_exit  = acc_done || (timer_q == TimerLast);
        unique case (state_q)
            StRun: begin
                if (ex_acc_start) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else if (ex_do_branch) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            StAccWait: begin
                if (!acc_exit) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            timer_q     <= '0;
            r1_fw_q     <= 2'd0;
            r2_fw_q     <= 2'd0;
            acc_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (ex_acc_start) begin
                        state_q <= StAccWait;
                        timer_q <= '0;
                    end
                end
                StAccWait: begin
                    if (acc_done) begin
                        state_q <= StRun;
                    end else if (timer_q == TimerLast) begin
                        state_q   <= StRun;
                        acc_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StRun;
            endcase

            if (stall_if) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_id) flush_cnt_q <= flush_cnt_q + 1'b1;

            // Selects follow the instruction as it moves ID->EX; a bubble carries no operands.
            if (!stall_id) begin
                if (bubble_ex) begin
                    r1_fw_q <= 2'd0;
                    r2_fw_q <= 2'd0;
                end else begin
                    r1_fw_q <= fw_sel(id_rs1, id_use_rs1, ex_w_idx, ex_wb_en, mem_w_idx, mem_wb_en);
                    r2_fw_q <= fw_sel(id_rs2, id_use_rs2, ex_w_idx, ex_wb_en, mem_w_idx, mem_wb_en);
                end
            end
        end
    end

    assign r1_fw_sel = r1_fw_q;
    assign r2_fw_sel = r2_fw_q;
    assign acc_err   = acc_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding, load-use, branch priority, coprocessor
// completion and timeout, and reset during a coprocessor wait.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_w_idx, mem_w_idx;
    logic        id_use_rs1, id_use_rs2, ex_wb_en, ex_is_load, mem_wb_en;
    logic        ex_do_branch, ex_acc_start, acc_done;
    logic [1:0]  r1_fw_sel, r2_fw_sel;
    logic        stall_if, stall_id, stall_ex, bubble_ex, flush_id, acc_err;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.ACC_TIMEOUT(8), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_w_idx(ex_w_idx), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .mem_w_idx(mem_w_idx), .mem_wb_en(mem_wb_en),
        .ex_do_branch(ex_do_branch), .ex_acc_start(ex_acc_start), .acc_done(acc_done),
        .r1_fw_sel(r1_fw_sel), .r2_fw_sel(r2_fw_sel),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .flush_id(flush_id), .acc_err(acc_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs then settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_w_idx = 0; ex_wb_en = 0; ex_is_load = 0;
        mem_w_idx = 0; mem_wb_en = 0;
        ex_do_branch = 0; ex_acc_start = 0; acc_done = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_r1", 32'(r1_fw_sel), 0);
        check("rst_r2", 32'(r2_fw_sel), 0);
        check("rst_err", 32'(acc_err), 0);
        check("rst_scnt", stall_cnt, 0);
        check("rst_fcnt", flush_cnt, 0);
        check("rst_stall", 32'(stall_if), 0);

        // Forwarding: EX beats MEM, x0 never forwards.
        id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
        ex_w_idx = 5; ex_wb_en = 1; mem_w_idx = 5; mem_wb_en = 1;
        #1;
        check("fw_nostall", 32'(stall_if), 0);
        step();
        check("fw_ex_r1", 32'(r1_fw_sel), 1);
        check("fw_x0_r2", 32'(r2_fw_sel), 0);
        ex_w_idx = 6;
        step();
        check("fw_mem_r1", 32'(r1_fw_sel), 2);
        id_use_rs1 = 0;
        step();
        check("fw_unused_r1", 32'(r1_fw_sel), 0);

        // Load-use: one stall cycle with bubble, then MEM forwarding on both operands.
        idle_inputs();
        ex_w_idx = 7; ex_wb_en = 1; ex_is_load = 1;
        id_rs1 = 7; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
        #1;
        check("lu_stall_if", 32'(stall_if), 1);
        check("lu_stall_id", 32'(stall_id), 1);
        check("lu_bubble", 32'(bubble_ex), 1);
        check("lu_stall_ex", 32'(stall_ex), 0);
        check("lu_flush", 32'(flush_id), 0);
        step();
        ex_wb_en = 0; ex_is_load = 0; ex_w_idx = 0;
        mem_w_idx = 7; mem_wb_en = 1;
        #1;
        check("lu_released", 32'(stall_if), 0);
        step();
        check("lu_r1", 32'(r1_fw_sel), 2);
        check("lu_r2", 32'(r2_fw_sel), 2);
        check("lu_scnt", stall_cnt, 1);

        // Branch beats load-use.
        idle_inputs();
        ex_w_idx = 9; ex_wb_en = 1; ex_is_load = 1; id_rs1 = 9; id_use_rs1 = 1;
        ex_do_branch = 1;
        #1;
        check("br_flush", 32'(flush_id), 1);
        check("br_bubble", 32'(bubble_ex), 1);
        check("br_nostall", 32'(stall_if), 0);
        step();
        check("br_fcnt", flush_cnt, 1);
        check("br_scnt", stall_cnt, 1);
        check("br_r1_bubble", 32'(r1_fw_sel), 0);

        // Coprocessor finishing on the sixth cycle: six stalled cycles.
        idle_inputs();
        ex_acc_start = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("acc_stall_if", 32'(stall_if), 1);
            check("acc_stall_ex", 32'(stall_ex), 1);
            step();
        end
        acc_done = 1;
        #1;
        check("acc_done_if", 32'(stall_if), 0);
        check("acc_done_ex", 32'(stall_ex), 0);
        step();
        idle_inputs();
        check("acc_err0", 32'(acc_err), 0);
        check("acc_scnt", stall_cnt, 7);
        acc_done = 1;
        #1;
        check("done_in_run", 32'(stall_if), 0);
        step();
        acc_done = 0;

        // Timeout: eight stalled cycles, then sticky error; branches ignored while waiting.
        ex_acc_start = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) ex_do_branch = 1;
            #1;
            check("to_stall_if", 32'(stall_if), 1);
            if (i == 3) check("to_br_ignored", 32'(flush_id), 0);
            step();
            ex_do_branch = 0;
        end
        #1;
        check("to_release", 32'(stall_if), 0);
        step();
        ex_acc_start = 0;
        #1;
        check("to_err", 32'(acc_err), 1);
        check("to_scnt", stall_cnt, 15);
        check("to_fcnt", flush_cnt, 1);
        step();
        step();
        check("to_err_sticky", 32'(acc_err), 1);
        check("to_idle", 32'(stall_if), 0);

        // Reset mid-wait returns to RUN with everything cleared.
        ex_acc_start = 1;
        step();
        #1;
        check("rw_waiting", 32'(stall_if), 1);
        rst = 1; ex_acc_start = 0;
        step();
        rst = 0;
        #1;
        check("rw_stall_if", 32'(stall_if), 0);
        check("rw_stall_ex", 32'(stall_ex), 0);
        check("rw_err", 32'(acc_err), 0);
        check("rw_scnt", stall_cnt, 0);
        check("rw_fcnt", flush_cnt, 0);
        ex_do_branch = 1;
        #1;
        check("rw_run_branch", 32'(flush_id), 1);
        step();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
